// File: rtl/damage_calculator_if.sv
// Bullet-store read port, player box and HUD outputs of damage_calculator.
// master = bullet store / game logic side, slave = damage_calculator.
interface damage_calculator_if;
    logic        start;
    logic [15:0] player_pos;
    logic [15:0] player_size;
    logic [2:0]  bullet_index;
    logic [15:0] bullet_pos;
    logic [15:0] bullet_size;
    logic [2:0]  bullet_color;
    logic        bullet_render;
    logic [7:0]  hp;
    logic        hit;
    logic        dead;
    logic        busy;
    logic        done;

    modport master (
        output start, player_pos, player_size, bullet_pos, bullet_size, bullet_color,
               bullet_render,
        input  bullet_index, hp, hit, dead, busy, done
    );

    modport slave (
        input  start, player_pos, player_size, bullet_pos, bullet_size, bullet_color,
               bullet_render,
        output bullet_index, hp, hit, dead, busy, done
    );
endinterface

// File: rtl/damage_calculator.sv
// Per-frame bullet/heart collision scan and HP update.
// Define DAMAGE_IFRAME_EN to add invincibility frames after each damaging frame.
module damage_calculator #(
    parameter int unsigned HP_MAX  = 20,
    parameter int unsigned DAMAGE  = 5,
    parameter int unsigned HEAL    = 3,
    parameter int unsigned IFRAMES = 3
) (
    input logic                clk,
    input logic                rst_n,
    damage_calculator_if.slave bus
);
    localparam logic [7:0] HpMax  = 8'(HP_MAX);
    localparam logic [7:0] Damage = 8'(DAMAGE);
    localparam logic [7:0] Heal   = 8'(HEAL);

    typedef enum logic [1:0] {StIdle, StScan, StApply} state_e;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] pp_q, pp_d, ps_q, ps_d;
    logic [15:0] last_pos_q, last_pos_d;
    logic        dmg_q, dmg_d, heal_q, heal_d;
    logic [7:0]  hp_q, hp_d;
    logic        hit_q, hit_d, done_q, done_d;
    logic        ifr_clear, apply_dmg;
    logic        overlap, moved;
    logic [8:0]  px_end, py_end, bx_end, by_end, heal_sum;

    // 9-bit box ends so boxes near the 255 edge do not wrap.
    always_comb begin
        px_end  = {1'b0, pp_q[15:8]} + {1'b0, ps_q[15:8]};
        py_end  = {1'b0, pp_q[7:0]} + {1'b0, ps_q[7:0]};
        bx_end  = {1'b0, bus.bullet_pos[15:8]} + {1'b0, bus.bullet_size[15:8]};
        by_end  = {1'b0, bus.bullet_pos[7:0]} + {1'b0, bus.bullet_size[7:0]};
        overlap = ({1'b0, bus.bullet_pos[15:8]} < px_end) && ({1'b0, pp_q[15:8]} < bx_end) &&
                  ({1'b0, bus.bullet_pos[7:0]} < py_end) && ({1'b0, pp_q[7:0]} < by_end) &&
                  (ps_q[15:8] != 8'd0) && (ps_q[7:0] != 8'd0) &&
                  (bus.bullet_size[15:8] != 8'd0) && (bus.bullet_size[7:0] != 8'd0);
        moved    = (pp_q != last_pos_q);
        heal_sum = {1'b0, hp_q} + {1'b0, Heal};
    end

    assign apply_dmg = (state_q == StApply) && dmg_q && ifr_clear;

`ifdef DAMAGE_IFRAME_EN
    logic [3:0] ifr_q, ifr_d;

    assign ifr_clear = (ifr_q == 4'd0);

    always_comb begin
        ifr_d = ifr_q;
        if (state_q == StApply) begin
            if (apply_dmg) begin
                ifr_d = 4'(IFRAMES);
            end else if (!ifr_clear) begin
                ifr_d = ifr_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifr_q <= 4'd0;
        end else begin
            ifr_q <= ifr_d;
        end
    end
`else
    assign ifr_clear = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pp_d       = pp_q;
        ps_d       = ps_q;
        last_pos_d = last_pos_q;
        dmg_d      = dmg_q;
        heal_d     = heal_q;
        hp_d       = hp_q;
        hit_d      = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StScan;
                    pp_d    = bus.player_pos;
                    ps_d    = bus.player_size;
                    idx_d   = 3'd0;
                    dmg_d   = 1'b0;
                    heal_d  = 1'b0;
                end
            end
            StScan: begin
                if (bus.bullet_render && overlap) begin
                    case (bus.bullet_color)
                        3'b000:  dmg_d  = 1'b1;
                        3'b001:  heal_d = 1'b1;
                        3'b010:  dmg_d  = dmg_q | moved;
                        default: ;
                    endcase
                end
                if (idx_q == 3'd7) begin
                    state_d = StApply;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            StApply: begin
                state_d    = StIdle;
                done_d     = 1'b1;
                last_pos_d = pp_q;
                if (apply_dmg) begin
                    hp_d  = (hp_q > Damage) ? hp_q - Damage : 8'd0;
                    hit_d = 1'b1;
                end else if (heal_q && hp_q != 8'd0) begin
                    hp_d = (heal_sum > {1'b0, HpMax}) ? HpMax : heal_sum[7:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= 3'd0;
            pp_q       <= 16'd0;
            ps_q       <= 16'd0;
            last_pos_q <= 16'd0;
            dmg_q      <= 1'b0;
            heal_q     <= 1'b0;
            hp_q       <= HpMax;
            hit_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pp_q       <= pp_d;
            ps_q       <= ps_d;
            last_pos_q <= last_pos_d;
            dmg_q      <= dmg_d;
            heal_q     <= heal_d;
            hp_q       <= hp_d;
            hit_q      <= hit_d;
            done_q     <= done_d;
        end
    end

    assign bus.bullet_index = idx_q;
    assign bus.hp           = hp_q;
    assign bus.hit          = hit_q;
    assign bus.dead         = (hp_q == 8'd0);
    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = done_q;
endmodule

// File: tb/tb_damage_calculator.sv
// Scoreboard bench for damage_calculator: a behavioural model predicts each frame's
// HP/hit result at start time; results are checked when done pulses.
module tb_damage_calculator;
    localparam int HpMax   = 20;
    localparam int Damage  = 5;
    localparam int Heal    = 3;
    localparam int Iframes = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    damage_calculator_if bus ();

    damage_calculator #(
        .HP_MAX (HpMax),
        .DAMAGE (Damage),
        .HEAL   (Heal),
        .IFRAMES(Iframes)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Bullet store model, read combinationally through bullet_index.
    logic [15:0] slot_pos   [8];
    logic [15:0] slot_size  [8];
    logic [2:0]  slot_color [8];
    logic        slot_render[8];

    assign bus.bullet_pos    = slot_pos[bus.bullet_index];
    assign bus.bullet_size   = slot_size[bus.bullet_index];
    assign bus.bullet_color  = slot_color[bus.bullet_index];
    assign bus.bullet_render = slot_render[bus.bullet_index];

    typedef struct {
        int   hp;
        logic hit;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fails = 0;
    int          m_hp, m_ifr;
    logic [15:0] m_last;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit boxes_hit(input logic [15:0] p, input logic [15:0] ps,
                                     input logic [15:0] b, input logic [15:0] bs);
        int px = p[15:8], py = p[7:0], pw = ps[15:8], ph = ps[7:0];
        int bx = b[15:8], by = b[7:0], bw = bs[15:8], bh = bs[7:0];
        if (pw == 0 || ph == 0 || bw == 0 || bh == 0) return 1'b0;
        return (bx < px + pw) && (px < bx + bw) && (by < py + ph) && (py < by + bh);
    endfunction

    task automatic model_reset();
        m_hp   = HpMax;
        m_ifr  = 0;
        m_last = 16'd0;
        sb_q.delete();
    endtask

    // Predict the frame using the current player inputs and store contents.
    task automatic model_scan();
        bit   dmg = 0, heal = 0;
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            if (slot_render[k] && boxes_hit(bus.player_pos, bus.player_size,
                                            slot_pos[k], slot_size[k])) begin
                if (slot_color[k] == 3'd0) dmg = 1;
                if (slot_color[k] == 3'd2 && bus.player_pos != m_last) dmg = 1;
                if (slot_color[k] == 3'd1) heal = 1;
            end
        end
        e.hit = 1'b0;
        if (dmg && m_ifr == 0) begin
            m_hp  = (m_hp > Damage) ? m_hp - Damage : 0;
            e.hit = 1'b1;
`ifdef DAMAGE_IFRAME_EN
            m_ifr = Iframes;
`endif
        end else begin
            if (heal && m_hp != 0) m_hp = (m_hp + Heal > HpMax) ? HpMax : m_hp + Heal;
            if (m_ifr != 0) m_ifr--;
        end
        m_last = bus.player_pos;
        e.hp   = m_hp;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb_q.size() == 0) begin
                check_val("done_unexpected", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("hp", int'(bus.hp), mon_e.hp);
                check_val("hit", int'(bus.hit), int'(mon_e.hit));
                check_val("dead", int'(bus.dead), int'(mon_e.hp == 0));
            end
        end else if (rst_n && bus.hit) begin
            check_val("hit_without_done", 1, 0);
        end
    end

    task automatic do_reset();
        bus.start = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic clear_slots();
        for (int k = 0; k < 8; k++) begin
            slot_pos[k]    = 16'd0;
            slot_size[k]   = 16'd0;
            slot_color[k]  = 3'd0;
            slot_render[k] = 1'b0;
        end
    endtask

    task automatic set_slot(input int k, input logic [15:0] pos, input logic [15:0] size,
                            input logic [2:0] color);
        slot_pos[k]    = pos;
        slot_size[k]   = size;
        slot_color[k]  = color;
        slot_render[k] = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) check_val("done_timeout", 0, 1);
    endtask

    task automatic run_scan();
        model_scan();
        pulse_start();
        wait_done();
    endtask

    task automatic run_idle_scans(input int n);
        logic [15:0] sp [8];
        logic        sr [8];
        for (int k = 0; k < 8; k++) begin
            sr[k]          = slot_render[k];
            slot_render[k] = 1'b0;
            sp[k]          = slot_pos[k];
        end
        repeat (n) run_scan();
        for (int k = 0; k < 8; k++) begin
            slot_render[k] = sr[k];
            slot_pos[k]    = sp[k];
        end
    endtask

    initial begin
        int busy_cnt, lat, idx_at3;
        bus.start       = 1'b0;
        bus.player_pos  = 16'h4010;
        bus.player_size = 16'h1010;
        clear_slots();
        do_reset();

        // Reset state
        check_val("rst_hp", int'(bus.hp), HpMax);
        check_val("rst_busy", int'(bus.busy), 0);
        check_val("rst_done", int'(bus.done), 0);
        check_val("rst_hit", int'(bus.hit), 0);
        check_val("rst_dead", int'(bus.dead), 0);
        check_val("rst_index", int'(bus.bullet_index), 0);

        // Empty scan: timing of busy/done/index; a start while busy is dropped
        model_scan();
        pulse_start();
        busy_cnt = 0;
        lat      = 0;
        idx_at3  = -1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done && lat == 0) lat = i;
            if (i == 3) idx_at3 = int'(bus.bullet_index);
            if (i == 4) bus.start = 1'b1;
            if (i == 5) bus.start = 1'b0;
        end
        check_val("busy_cycles", busy_cnt, 9);
        check_val("done_latency", lat, 10);
        check_val("index_scan", idx_at3, 2);
        check_val("hp_empty", int'(bus.hp), HpMax);

        // White hit, then iframe behaviour over four repeats
        set_slot(2, 16'h4818, 16'h0404, 3'd0);
        run_scan();
        check_val("hp_first_hit", int'(bus.hp), 15);
        repeat (4) run_scan();

        // Edge-touching bullet is not a hit
        do_reset();
        clear_slots();
        set_slot(2, 16'h5018, 16'h0404, 3'd0);
        run_scan();
        check_val("hp_edge", int'(bus.hp), HpMax);

        // Wide box near x=255 needs the 9-bit compare
        bus.player_pos = 16'hF010;
        clear_slots();
        set_slot(5, 16'hF810, 16'h1004, 3'd0);
        run_scan();
        check_val("hp_wrap", int'(bus.hp), 15);

        // Blue: damages only when the player moved since the last frame
        do_reset();
        bus.player_pos = 16'h4010;
        clear_slots();
        set_slot(0, 16'h4414, 16'h0404, 3'd2);
        repeat (5) run_scan();
        check_val("hp_blue_still", int'(bus.hp), 15);
        bus.player_pos = 16'h4110;
        run_scan();
        check_val("hp_blue_moved", int'(bus.hp), 10);

        // Green heal with saturation
        do_reset();
        bus.player_pos = 16'h4010;
        clear_slots();
        set_slot(1, 16'h4414, 16'h0404, 3'd0);
        run_scan();
        clear_slots();
        set_slot(3, 16'h4414, 16'h0404, 3'd1);
        run_scan();
        run_scan();
        check_val("hp_heal_sat", int'(bus.hp), HpMax);

        // White plus green: damage wins
        do_reset();
        set_slot(6, 16'h4C1C, 16'h0404, 3'd0);
        run_scan();
        check_val("hp_white_green", int'(bus.hp), 15);

        // Drive hp down to 3, then to 0; heal is then blocked
        do_reset();
        clear_slots();
        set_slot(1, 16'h4414, 16'h0404, 3'd0);
        for (int j = 0; j < 3; j++) begin
            run_scan();
            run_idle_scans(Iframes);
        end
        clear_slots();
        set_slot(3, 16'h4414, 16'h0404, 3'd1);
        run_scan();
        clear_slots();
        set_slot(1, 16'h4414, 16'h0404, 3'd0);
        run_scan();
        check_val("hp_three", int'(bus.hp), 3);
        run_idle_scans(Iframes);
        run_scan();
        check_val("hp_zero", int'(bus.hp), 0);
        check_val("dead_level", int'(bus.dead), 1);
        clear_slots();
        set_slot(3, 16'h4414, 16'h0404, 3'd1);
        run_scan();
        check_val("hp_dead_heal", int'(bus.hp), 0);

        // Reset in the middle of a damaging scan aborts it
        do_reset();
        clear_slots();
        set_slot(1, 16'h4414, 16'h0404, 3'd0);
        run_scan();
        run_idle_scans(Iframes);
        pulse_start();
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_val("abort_hp", int'(bus.hp), HpMax);
        check_val("abort_busy", int'(bus.busy), 0);
        check_val("abort_done", int'(bus.done), 0);
        check_val("abort_hit", int'(bus.hit), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_val("abort_hp_after", int'(bus.hp), HpMax);

        check_val("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
